mux8_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the 8:1 bit multiplexer (HW2_mux8to1) between 8 requesters. It registers a one-hot grant, drives the mux select, and gates the mux output. A requester holds its request for the duration of its access and releases the mux by dropping the request. It sits directly in front of the mux and owns its `sel` input.

---
 rtl/mux8_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter owning the select of an 8:1 bit mux; one registered one-hot grant at a time.
// Optional grant timeout is enabled by defining MUX8_ARB_TIMEOUT_EN (limit set by HOLD_MAX).

module HW2_mux8to1 (
  input  logic [7:0] in,
  input  logic [2:0] sel,
  output logic       out
);
  assign out = in[sel];
endmodule

module mux8_rr_arbiter #(
  parameter int REQ_NUM = 8,
  parameter int SEL_W   = 3
`ifdef MUX8_ARB_TIMEOUT_EN
  , parameter int HOLD_MAX = 4
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REQ_NUM-1:0] req,
  input  logic [REQ_NUM-1:0] in,
  output logic [REQ_NUM-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               out
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [REQ_NUM-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               busy_q, busy_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic               found;
  logic [SEL_W-1:0]   pick;
  logic [SEL_W-1:0]   idx;
  logic               timeoutHit;
  logic               muxOut;

  // First set request scanning upward from ptr and wrapping; only consumed in IDLE.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      idx = ptr_q + SEL_W'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

`ifdef MUX8_ARB_TIMEOUT_EN
  logic [7:0] holdCnt_q, holdCnt_d;

  always_comb begin
    holdCnt_d = holdCnt_q;
    if (state_q == IDLE) begin
      holdCnt_d = '0;
    end else if (holdCnt_q != 8'hFF) begin
      holdCnt_d = holdCnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdCnt_q <= '0;
    end else begin
      holdCnt_q <= holdCnt_d;
    end
  end

  assign timeoutHit = (state_q == GRANT) && (holdCnt_q == 8'(HOLD_MAX - 1));
`else
  assign timeoutHit = 1'b0;
`endif

  // Only req[sel] is examined while granted, so other request lines cannot disturb a grant.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (found) begin
          state_d     = GRANT;
          gnt_d[pick] = 1'b1;
          sel_d       = pick;
          busy_d      = 1'b1;
        end
      end
      GRANT: begin
        if (!req[sel_q] || timeoutHit) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = sel_q + SEL_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
    end
  end

  HW2_mux8to1 u_mux (
    .in  (in),
    .sel (sel_q),
    .out (muxOut)
  );

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;
  assign out  = busy_q & muxOut;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: reset, single grant, round robin, wrap/fairness,
// optional timeout and asynchronous reset during a grant.

module tb_mux8_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] in;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       out;

  int compareCount  = 0;
  int mismatchCount = 0;

  mux8_rr_arbiter dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .in   (in),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] reqVal, input logic [7:0] inVal);
    req = reqVal;
    in  = inVal;
  endtask

  task automatic checkValue(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expGnt, input logic [2:0] expSel,
                             input logic expBusy, input logic expOut);
    checkValue({tag, ".gnt"}, gnt, expGnt);
    checkValue({tag, ".sel"}, {5'd0, sel}, {5'd0, expSel});
    checkValue({tag, ".busy"}, {7'd0, busy}, {7'd0, expBusy});
    checkValue({tag, ".out"}, {7'd0, out}, {7'd0, expOut});
  endtask

  initial begin
    logic [7:0] rrIn;
    logic [2:0] idx;
    logic [7:0] oneHot;

    rst_n = 1'b1;
    applyStimulus(8'hFF, 8'hFF);
    #2 rst_n = 1'b0;
    #1 checkOutput("reset_async", 8'h00, 3'd0, 1'b0, 1'b0);

    // Reset held with every request active
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("reset_hold", 8'h00, 3'd0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    applyStimulus(8'h00, 8'h00);
    tick();
    checkOutput("idle_after_reset", 8'h00, 3'd0, 1'b0, 1'b0);

    // Single requester 3
    applyStimulus(8'h08, 8'b0000_1000);
    tick();
    checkOutput("single_grant", 8'h08, 3'd3, 1'b1, 1'b1);
    in = 8'h00;
    #1 checkOutput("single_out_comb", 8'h08, 3'd3, 1'b1, 1'b0);
    in = 8'b0000_1000;
    tick();
    checkOutput("single_hold1", 8'h08, 3'd3, 1'b1, 1'b1);
    tick();
    checkOutput("single_hold2", 8'h08, 3'd3, 1'b1, 1'b1);
    req = 8'h00;
    tick();
    checkOutput("single_release", 8'h00, 3'd3, 1'b0, 1'b0);

    // Round robin from a fresh pointer
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    checkOutput("rr_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rrIn = 8'b1010_0110;
    applyStimulus(8'hFF, rrIn);
    for (int k = 0; k < 9; k++) begin
      idx    = 3'(k % 8);
      oneHot = 8'h01 << idx;
      tick();
      checkOutput("rr_grant_a", oneHot, idx, 1'b1, rrIn[idx]);
      tick();
      checkOutput("rr_grant_b", oneHot, idx, 1'b1, rrIn[idx]);
      req[idx] = 1'b0;
      tick();
      checkOutput("rr_bubble", 8'h00, idx, 1'b0, 1'b0);
      req = 8'hFF;
    end

    // Wrap and fairness: 6, then 7, then 0 rather than 7 again
    applyStimulus(8'h40, 8'hFF);
    tick();
    checkOutput("wrap_g6", 8'h40, 3'd6, 1'b1, 1'b1);
    req = 8'h00;
    tick();
    checkOutput("wrap_rel6", 8'h00, 3'd6, 1'b0, 1'b0);
    req = 8'h81;
    tick();
    checkOutput("wrap_g7", 8'h80, 3'd7, 1'b1, 1'b1);
    tick();
    checkOutput("wrap_g7_hold", 8'h80, 3'd7, 1'b1, 1'b1);
    req = 8'h01;
    tick();
    checkOutput("wrap_rel7", 8'h00, 3'd7, 1'b0, 1'b0);
    req = 8'h81;
    tick();
    checkOutput("wrap_g0", 8'h01, 3'd0, 1'b1, 1'b1);
    req = 8'bxxxx_xxx1;
    tick();
    checkOutput("x_other_req", 8'h01, 3'd0, 1'b1, 1'b1);
    req = 8'h00;
    tick();
    checkOutput("x_release", 8'h00, 3'd0, 1'b0, 1'b0);

    // Long hold with requesters 0 and 2
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    applyStimulus(8'h05, 8'h05);
`ifdef MUX8_ARB_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("to_g0", 8'h01, 3'd0, 1'b1, 1'b1);
    end
    tick();
    checkOutput("to_bubble0", 8'h00, 3'd0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("to_g2", 8'h04, 3'd2, 1'b1, 1'b1);
    end
    tick();
    checkOutput("to_bubble2", 8'h00, 3'd2, 1'b0, 1'b0);
    tick();
    checkOutput("to_g0_again", 8'h01, 3'd0, 1'b1, 1'b1);
`else
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput("nto_g0", 8'h01, 3'd0, 1'b1, 1'b1);
    end
`endif
    req = 8'h00;
    tick();
    checkOutput("long_release", 8'h00, 3'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a grant to requester 5
    applyStimulus(8'h20, 8'h20);
    tick();
    checkOutput("ar_g5", 8'h20, 3'd5, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1 checkOutput("ar_dropped", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    req = 8'hFF;
    @(negedge clk);
    tick();
    checkOutput("ar_next_g0", 8'h01, 3'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
